// File: rtl/ir_point_filter_pkg.sv
// Shared types and constants for the IR point filter: FSM states, window actions,
// X/Y field positions and default parameter values.
package ir_point_filter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_LOST  = 2'd2
    } ir_state_e;

    typedef enum logic [1:0] {
        ACT_NONE    = 2'd0,
        ACT_PRELOAD = 2'd1,
        ACT_SHIFT   = 2'd2
    } ir_act_e;

    localparam int IR_X_MSB = 15;
    localparam int IR_X_LSB = 8;
    localparam int IR_Y_MSB = 7;
    localparam int IR_Y_LSB = 0;

    localparam int unsigned IR_TIMEOUT_CYCLES_DEFAULT = 32'd5000000;
    localparam int unsigned IR_JUMP_MAX_DEFAULT       = 32'd32;

    function automatic logic [7:0] abs_diff8(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/ir_point_filter_axis_avg.sv
// One axis of the IR point filter: a 4-entry sample window with a running
// 10-bit sum; the output is floor(sum/4).
module ir_axis_avg (
    input  logic       clock,
    input  logic       resetn,
    input  logic       preload_i,
    input  logic       shift_i,
    input  logic [7:0] sample_i,
    output logic [7:0] avg_o
);

    logic [7:0] win_q [4];
    logic [9:0] sum_q;

    // Window and running sum; preload fills every entry so the average equals the sample.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) begin
                win_q[i] <= 8'h00;
            end
            sum_q <= 10'd0;
        end else if (preload_i) begin
            for (int i = 0; i < 4; i++) begin
                win_q[i] <= sample_i;
            end
            sum_q <= {sample_i, 2'b00};
        end else if (shift_i) begin
            win_q[0] <= sample_i;
            win_q[1] <= win_q[0];
            win_q[2] <= win_q[1];
            win_q[3] <= win_q[2];
            sum_q    <= sum_q + {2'b00, sample_i} - {2'b00, win_q[3]};
        end else begin
            sum_q <= sum_q;
        end
    end

    assign avg_o = 8'(sum_q >> 2);

endmodule

// File: rtl/ir_point_filter.sv
// IR point filter top: 2-cycle pipeline (strobe decode -> window update -> output),
// tracking FSM with saturating timeout. Optional outlier rejection: IR_FILTER_OUTLIER_REJECT_EN.
module ir_point_filter
    import ir_point_filter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = IR_TIMEOUT_CYCLES_DEFAULT,
    parameter int unsigned JUMP_MAX       = IR_JUMP_MAX_DEFAULT
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [15:0] ir_raw,
    input  logic        ir_valid,
    output logic [15:0] ir_out,
    output logic        ir_out_valid,
    output logic        ir_lost
);

    localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES + 32'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);

    ir_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    ir_act_e           act_q, act_d;
    logic [15:0]       raw_q;
    logic              upd_q;
    logic [15:0]       ir_out_q;
    logic              ir_out_valid_q;
    logic              ir_lost_q;
    logic [7:0]        avg_x_s, avg_y_s;

`ifdef IR_FILTER_OUTLIER_REJECT_EN
    logic [1:0]        rej_q, rej_d;
    logic              outlier_s;

    // Compared against the current window average, i.e. the value ir_out settles to.
    assign outlier_s = (32'(abs_diff8(ir_raw[IR_X_MSB:IR_X_LSB], avg_x_s)) > JUMP_MAX) ||
                       (32'(abs_diff8(ir_raw[IR_Y_MSB:IR_Y_LSB], avg_y_s)) > JUMP_MAX);
`endif

    // Tracking FSM, timeout counter and per-strobe window action.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        act_d   = ACT_NONE;
`ifdef IR_FILTER_OUTLIER_REJECT_EN
        rej_d   = rej_q;
`endif
        case (state_q)
            ST_IDLE, ST_LOST: begin
                if (ir_valid) begin
                    act_d   = ACT_PRELOAD;
                    state_d = ST_TRACK;
                    cnt_d   = '0;
`ifdef IR_FILTER_OUTLIER_REJECT_EN
                    rej_d   = 2'd0;
`endif
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_TRACK: begin
                if (ir_valid) begin
                    cnt_d = '0;
`ifdef IR_FILTER_OUTLIER_REJECT_EN
                    if (!outlier_s) begin
                        act_d = ACT_SHIFT;
                        rej_d = 2'd0;
                    end else if (rej_q == 2'd2) begin
                        act_d = ACT_PRELOAD;
                        rej_d = 2'd0;
                    end else begin
                        act_d = ACT_NONE;
                        rej_d = rej_q + 2'd1;
                    end
`else
                    act_d = ACT_SHIFT;
`endif
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = ST_LOST;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, pipeline and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            act_q          <= ACT_NONE;
            raw_q          <= 16'h0000;
            upd_q          <= 1'b0;
            ir_out_q       <= 16'h0000;
            ir_out_valid_q <= 1'b0;
            ir_lost_q      <= 1'b0;
`ifdef IR_FILTER_OUTLIER_REJECT_EN
            rej_q          <= 2'd0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            act_q          <= act_d;
            raw_q          <= ir_raw;
            upd_q          <= (act_q != ACT_NONE);
            ir_out_q       <= upd_q ? {avg_x_s, avg_y_s} : ir_out_q;
            ir_out_valid_q <= upd_q;
            ir_lost_q      <= (state_d == ST_LOST);
`ifdef IR_FILTER_OUTLIER_REJECT_EN
            rej_q          <= rej_d;
`endif
        end
    end

    ir_axis_avg u_axis_x (
        .clock     (clock),
        .resetn    (resetn),
        .preload_i (act_q == ACT_PRELOAD),
        .shift_i   (act_q == ACT_SHIFT),
        .sample_i  (raw_q[IR_X_MSB:IR_X_LSB]),
        .avg_o     (avg_x_s)
    );

    ir_axis_avg u_axis_y (
        .clock     (clock),
        .resetn    (resetn),
        .preload_i (act_q == ACT_PRELOAD),
        .shift_i   (act_q == ACT_SHIFT),
        .sample_i  (raw_q[IR_Y_MSB:IR_Y_LSB]),
        .avg_o     (avg_y_s)
    );

    assign ir_out       = ir_out_q;
    assign ir_out_valid = ir_out_valid_q;
    assign ir_lost      = ir_lost_q;

endmodule

// File: tb/tb_ir_point_filter.sv
// Directed self-checking bench for ir_point_filter (TIMEOUT_CYCLES=10).
module tb_ir_point_filter;

    logic        clock;
    logic        resetn;
    logic [15:0] ir_raw;
    logic        ir_valid;
    logic [15:0] ir_out;
    logic        ir_out_valid;
    logic        ir_lost;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses;
    logic [15:0] exp27 [4];
    logic [15:0] expb  [4];

    ir_point_filter #(.TIMEOUT_CYCLES(10), .JUMP_MAX(32)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .ir_raw       (ir_raw),
        .ir_valid     (ir_valid),
        .ir_out       (ir_out),
        .ir_out_valid (ir_out_valid),
        .ir_lost      (ir_lost)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [15:0] v);
        ir_raw   = v;
        ir_valid = 1'b1;
        tick();
        ir_valid = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        exp27 = '{16'h0200, 16'h0400, 16'h0600, 16'h0800};
        expb  = '{16'h0A00, 16'h0C00, 16'h0E00, 16'h1000};
        resetn   = 1'b0;
        ir_valid = 1'b0;
        ir_raw   = 16'h0000;
        #2;
        check("rst_out",   ir_out,              16'h0000);
        check("rst_valid", {15'd0, ir_out_valid}, 16'h0000);
        check("rst_lost",  {15'd0, ir_lost},      16'h0000);
        tick();
        tick();
        resetn = 1'b1;

        // First edge after reset release carries a strobe; 2-cycle latency
        send(16'h4020);
        check("lat_n0_valid", {15'd0, ir_out_valid}, 16'h0000);
        tick();
        check("lat_n1_valid", {15'd0, ir_out_valid}, 16'h0000);
        tick();
        check("lat_n2_valid", {15'd0, ir_out_valid}, 16'h0001);
        check("lat_n2_out",   ir_out,                16'h4020);
        check("lat_n2_lost",  {15'd0, ir_lost},      16'h0000);
        tick();
        check("lat_single_pulse", {15'd0, ir_out_valid}, 16'h0000);

        // IDLE: timeout does not run
        do_reset();
        repeat (15) tick();
        check("idle_lost", {15'd0, ir_lost}, 16'h0000);
        check("idle_out",  ir_out,           16'h0000);

        // Averaging from a zero preload
        send(16'h0000);
        tick();
        tick();
        check("pre0_out",   ir_out,                16'h0000);
        check("pre0_valid", {15'd0, ir_out_valid}, 16'h0001);
        for (int k = 0; k < 4; k++) begin
            send(16'h0800);
            tick();
            tick();
            check("avg8_out", ir_out, exp27[k]);
        end

        // Strobe on every cycle: X=16 into a window of 8s
        ir_raw   = 16'h1000;
        ir_valid = 1'b1;
        tick();
        tick();
        tick();
        check("burst0_out",   ir_out,                expb[0]);
        check("burst0_valid", {15'd0, ir_out_valid}, 16'h0001);
        tick();
        check("burst1_out", ir_out, expb[1]);
        ir_valid = 1'b0;
        tick();
        check("burst2_out",   ir_out,                expb[2]);
        check("burst2_valid", {15'd0, ir_out_valid}, 16'h0001);
        tick();
        check("burst3_out",   ir_out,                expb[3]);
        check("burst3_valid", {15'd0, ir_out_valid}, 16'h0001);
        tick();
        check("burst_end_valid", {15'd0, ir_out_valid}, 16'h0000);

        // Large jump while tracking 4040
        do_reset();
        send(16'h4040);
        tick();
        tick();
        check("jump_base", ir_out, 16'h4040);
`ifdef IR_FILTER_OUTLIER_REJECT_EN
        send(16'hC040);
        tick();
        tick();
        check("rej1_valid", {15'd0, ir_out_valid}, 16'h0000);
        send(16'hC040);
        tick();
        tick();
        check("rej2_valid", {15'd0, ir_out_valid}, 16'h0000);
        send(16'hC040);
        tick();
        tick();
        check("resync_out",   ir_out,                16'hC040);
        check("resync_valid", {15'd0, ir_out_valid}, 16'h0001);
`else
        send(16'hC040);
        tick();
        tick();
        check("jump_out",   ir_out,                16'h6040);
        check("jump_valid", {15'd0, ir_out_valid}, 16'h0001);
`endif

        // Timeout: ir_lost rises exactly 10 cycles after the last strobe
        do_reset();
        send(16'h2233);
        tick();
        tick();
        check("to_base_out", ir_out, 16'h2233);
        repeat (7) tick();
        check("to_n9_lost", {15'd0, ir_lost}, 16'h0000);
        tick();
        check("to_n10_lost", {15'd0, ir_lost}, 16'h0001);
        check("to_n10_out",  ir_out,           16'h2233);
        repeat (5) tick();
        check("lost_hold_lost", {15'd0, ir_lost}, 16'h0001);
        check("lost_hold_out",  ir_out,           16'h2233);
        send(16'h1111);
        check("relock_lost", {15'd0, ir_lost}, 16'h0000);
        tick();
        tick();
        check("relock_out",   ir_out,                16'h1111);
        check("relock_valid", {15'd0, ir_out_valid}, 16'h0001);

        // Strobe on the expiry cycle keeps tracking and restarts the count
        repeat (7) tick();
        send(16'h1111);
        check("expiry_race_lost", {15'd0, ir_lost}, 16'h0000);
        tick();
        tick();
        check("expiry_race_out",   ir_out,                16'h1111);
        check("expiry_race_valid", {15'd0, ir_out_valid}, 16'h0001);
        repeat (7) tick();
        check("restart_n9_lost", {15'd0, ir_lost}, 16'h0000);
        tick();
        check("restart_n10_lost", {15'd0, ir_lost}, 16'h0001);

        // Reset one cycle after a strobe discards it
        send(16'h5555);
        resetn = 1'b0;
        #1;
        check("midrst_out",   ir_out,                16'h0000);
        check("midrst_valid", {15'd0, ir_out_valid}, 16'h0000);
        check("midrst_lost",  {15'd0, ir_lost},      16'h0000);
        tick();
        resetn = 1'b1;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (ir_out_valid) pulses++;
        end
        check("midrst_pulses",    16'(pulses), 16'h0000);
        check("midrst_out_after", ir_out,      16'h0000);

        send(16'h7788);
        tick();
        tick();
        check("post_rst_out",   ir_out,                16'h7788);
        check("post_rst_valid", {15'd0, ir_out_valid}, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
